// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcode values, NOP word, immediate limits and the
// field bundle handed from the encoder front end to the packer.
package rv32_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned OPC_W    = 7;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned FUNCT3_W = 3;
    localparam int unsigned FUNCT7_W = 7;

    localparam logic [OPC_W-1:0] OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OP     = 7'b0110011;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    localparam int IMM_I_MIN = -2048;
    localparam int IMM_I_MAX = 2047;
    localparam int IMM_B_MIN = -4096;
    localparam int IMM_B_MAX = 4094;
    localparam int IMM_J_MIN = -1048576;
    localparam int IMM_J_MAX = 1048574;

    typedef struct packed {
        logic [FUNCT7_W-1:0] funct7;
        logic [REG_W-1:0]    rs2;
        logic [REG_W-1:0]    rs1;
        logic [FUNCT3_W-1:0] funct3;
        logic [REG_W-1:0]    rd;
        logic [OPC_W-1:0]    opcode;
        logic [XLEN-1:0]     imm;
    } enc_fields_t;

    function automatic logic imm_in_range(input logic signed [XLEN-1:0] v,
                                          input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer with immediate range/alignment checking.
// Any rejected field set is replaced by the canonical NOP.
module instr_pack
    import rv32_pkg::*;
(
    input  enc_fields_t     fields_i,
    output logic [XLEN-1:0] instr_o_c,
    output logic            err_o_c
);

    logic signed [XLEN-1:0] simm;
    logic [XLEN-1:0]        word;
    logic                   bad;

    assign simm = $signed(fields_i.imm);

    always_comb begin
        word = NOP;
        bad  = 1'b0;
        unique case (fields_i.opcode)
            OP_IMM, LOAD, JALR: begin
                bad  = !imm_in_range(simm, IMM_I_MIN, IMM_I_MAX);
                word = {fields_i.imm[11:0], fields_i.rs1, fields_i.funct3,
                        fields_i.rd, fields_i.opcode};
            end
            STORE: begin
                bad  = !imm_in_range(simm, IMM_I_MIN, IMM_I_MAX);
                word = {fields_i.imm[11:5], fields_i.rs2, fields_i.rs1, fields_i.funct3,
                        fields_i.imm[4:0], fields_i.opcode};
            end
            BRANCH: begin
                bad  = !imm_in_range(simm, IMM_B_MIN, IMM_B_MAX) || fields_i.imm[0];
                word = {fields_i.imm[12], fields_i.imm[10:5], fields_i.rs2, fields_i.rs1,
                        fields_i.funct3, fields_i.imm[4:1], fields_i.imm[11], fields_i.opcode};
            end
            JAL: begin
                bad  = !imm_in_range(simm, IMM_J_MIN, IMM_J_MAX) || fields_i.imm[0];
                word = {fields_i.imm[20], fields_i.imm[10:1], fields_i.imm[11],
                        fields_i.imm[19:12], fields_i.rd, fields_i.opcode};
            end
            LUI, AUIPC: begin
                bad  = (fields_i.imm[11:0] != 12'h000);
                word = {fields_i.imm[31:12], fields_i.rd, fields_i.opcode};
            end
            OP: begin
                word = {fields_i.funct7, fields_i.rs2, fields_i.rs1, fields_i.funct3,
                        fields_i.rd, fields_i.opcode};
            end
            default: bad = 1'b1;
        endcase
    end

    assign instr_o_c = bad ? NOP : word;
    assign err_o_c   = bad;

endmodule

// File: rtl/instr_enc.sv
// Streaming RV32I encoder: one valid/ready output stage holding the packed word,
// a wrapping word-address counter and a saturating error counter.
module instr_enc
    import rv32_pkg::*;
#(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPC_W-1:0]    opcode,
    input  logic [REG_W-1:0]    rd,
    input  logic [REG_W-1:0]    rs1,
    input  logic [REG_W-1:0]    rs2,
    input  logic [FUNCT3_W-1:0] funct3,
    input  logic [FUNCT7_W-1:0] funct7,
    input  logic [XLEN-1:0]     imm,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_instr,
    output logic [ADDR_W-1:0]   out_addr,
    output logic                out_err,
    output logic [7:0]          err_cnt
);

    localparam int unsigned     CNT_W     = 8;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);

    enc_fields_t         fields;
    logic [XLEN-1:0]     enc_instr_c;
    logic                enc_err_c;
    logic                in_hs, out_hs;

    logic                valid_q, valid_d;
    logic [XLEN-1:0]     instr_q, instr_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    assign fields = '{funct7: funct7, rs2: rs2, rs1: rs1, funct3: funct3,
                      rd: rd, opcode: opcode, imm: imm};

    instr_pack u_pack (
        .fields_i  (fields),
        .instr_o_c (enc_instr_c),
        .err_o_c   (enc_err_c)
    );

    assign in_ready = !valid_q || out_ready;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = valid_q && out_ready;

    // Next state; start outranks the output handshake for the counters only.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        err_d   = err_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        if (in_hs) begin
            valid_d = 1'b1;
            instr_d = enc_instr_c;
            err_d   = enc_err_c;
        end else if (out_hs) begin
            valid_d = 1'b0;
        end
        if (start) begin
            addr_d = ADDR_BASE;
            cnt_d  = '0;
        end else if (out_hs) begin
            addr_d = addr_q + ADDR_W'(1);
            if (err_q && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            err_q   <= 1'b0;
            addr_q  <= ADDR_BASE;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_err   = err_q;
    assign out_addr  = addr_q;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_instr_enc.sv
// Self-checking bench for instr_enc: directed encodings, backpressure, address wrap,
// start priority, err_cnt saturation, and randomized traffic against a reference model.
module tb_instr_enc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [1:0]  out_addr;
    logic        out_err;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;
    int addr_m = 0;
    int errs_m = 0;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [31:0] imm;
        logic [6:0]  op;
    } exp_t;

    instr_enc #(.ADDR_W(2), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr),
        .out_err(out_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Reference encoder built from the field-placement rules with shifts and masks.
    function automatic logic [32:0] model_enc(input logic [6:0] op, input logic [4:0] rd_v,
                                              input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                                              input logic [2:0] f3, input logic [6:0] f7,
                                              input logic [31:0] im);
        int s;
        logic [31:0] w;
        logic [31:0] regs;
        bit bad;
        s    = $signed(im);
        bad  = 1'b0;
        w    = 32'd0;
        regs = (32'(rs1_v) << 15) | (32'(f3) << 12);
        case (op)
            7'h13, 7'h03, 7'h67: begin
                bad = (s < -2048) || (s > 2047);
                w = ((im & 32'hFFF) << 20) | regs | (32'(rd_v) << 7);
            end
            7'h23: begin
                bad = (s < -2048) || (s > 2047);
                w = (((im >> 5) & 32'h7F) << 25) | (32'(rs2_v) << 20) | regs | ((im & 32'h1F) << 7);
            end
            7'h63: begin
                bad = (s < -4096) || (s > 4094) || ((s & 1) != 0);
                w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(rs2_v) << 20)
                    | regs | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
            end
            7'h6F: begin
                bad = (s < -1048576) || (s > 1048574) || ((s & 1) != 0);
                w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                    | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | (32'(rd_v) << 7);
            end
            7'h37, 7'h17: begin
                bad = (im % 32'd4096) != 32'd0;
                w = ((im / 32'd4096) * 32'd4096) | (32'(rd_v) << 7);
            end
            7'h33: w = (32'(f7) << 25) | (32'(rs2_v) << 20) | regs | (32'(rd_v) << 7);
            default: bad = 1'b1;
        endcase
        w = w | 32'(op);
        if (bad) w = 32'h0000_0013;
        return {bad, w};
    endfunction

    // Immediate decoder (as an instruction decoder would see it) for round-trip checks.
    function automatic logic [31:0] dec_imm(input logic [31:0] w);
        case (w[6:0])
            7'h13, 7'h03, 7'h67: return {{20{w[31]}}, w[31:20]};
            7'h23: return {{20{w[31]}}, w[31:25], w[11:7]};
            7'h63: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            7'h6F: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            7'h37, 7'h17: return {w[31:12], 12'h000};
            default: return 32'h0;
        endcase
    endfunction

    task automatic set_f(input logic [6:0] op, input logic [4:0] rd_v, input logic [4:0] rs1_v,
                         input logic [4:0] rs2_v, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] im);
        opcode = op; rd = rd_v; rs1 = rs1_v; rs2 = rs2_v; funct3 = f3; funct7 = f7; imm = im;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_f(7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr: got %h expected 0", out_instr); end
        checks++; if (out_addr !== 2'd0) begin errors++; $display("FAIL reset_out_addr: got %0d expected 0", out_addr); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b expected 0", out_err); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        addr_m = 0; errs_m = 0;
    endtask

    task automatic dir_one(input string nm, input logic [6:0] op, input logic [4:0] rd_v,
                           input logic [4:0] rs1_v, input logic [4:0] rs2_v, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] im,
                           input logic [31:0] exp_w, input logic exp_e);
        @(negedge clk);
        checks++; if (err_cnt !== 8'(errs_m)) begin errors++; $display("FAIL %s_err_cnt_before: got %0d expected %0d", nm, err_cnt, errs_m); end
        set_f(op, rd_v, rs1_v, rs2_v, f3, f7, im);
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b expected 1", nm, out_valid); end
        checks++; if (out_instr !== exp_w) begin errors++; $display("FAIL %s_instr: got %h expected %h", nm, out_instr, exp_w); end
        checks++; if (out_err !== exp_e) begin errors++; $display("FAIL %s_err: got %b expected %b", nm, out_err, exp_e); end
        checks++; if (out_addr !== 2'(addr_m)) begin errors++; $display("FAIL %s_addr: got %0d expected %0d", nm, out_addr, addr_m % 4); end
        addr_m++;
        if (exp_e) errs_m++;
    endtask

    task automatic test_directed();
        dir_one("addi_m1",   7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
        dir_one("beq_p8",    7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8,         32'h0020_8463, 1'b0);
        dir_one("beq_p7",    7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7,         32'h0000_0013, 1'b1);
        dir_one("jal_m4",    7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFFDF_F0EF, 1'b0);
        dir_one("lui_ok",    7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0);
        dir_one("lui_bad",   7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h0000_0013, 1'b1);
        dir_one("sw_m4",     7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFC, 32'hFE20_AE23, 1'b0);
        dir_one("add",       7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEAD_BEEF, 32'h0020_81B3, 1'b0);
        dir_one("addi_2047", 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047,      32'h7FF0_0013, 1'b0);
        dir_one("addi_2048", 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,      32'h0000_0013, 1'b1);
        dir_one("beq_4094",  7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094,      32'h7E00_0FE3, 1'b0);
        dir_one("beq_4096",  7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096,      32'h0000_0013, 1'b1);
        dir_one("unknown",   7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,         32'h0000_0013, 1'b1);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        checks++; if (err_cnt !== 8'(errs_m)) begin errors++; $display("FAIL bp_err_cnt: got %0d expected %0d", err_cnt, errs_m); end
        out_ready = 1'b0; in_valid = 1'b1;
        set_f(7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        @(negedge clk);
        set_f(7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6);
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_%0d: got %b expected 0", i, in_ready); end
            checks++; if (out_instr !== 32'h0050_0113) begin errors++; $display("FAIL bp_hold_%0d: got %h expected 00500113", i, out_instr); end
            checks++; if (out_addr !== 2'(addr_m)) begin errors++; $display("FAIL bp_addr_%0d: got %0d expected %0d", i, out_addr, addr_m % 4); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_instr !== 32'h0060_0193) begin errors++; $display("FAIL bp_word1: got %b/%h expected 1/00600193", out_valid, out_instr); end
        checks++; if (out_addr !== 2'(addr_m + 1)) begin errors++; $display("FAIL bp_addr1: got %0d expected %0d", out_addr, (addr_m + 1) % 4); end
        set_f(7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_instr !== 32'h0070_0213) begin errors++; $display("FAIL bp_word2: got %b/%h expected 1/00700213", out_valid, out_instr); end
        checks++; if (out_addr !== 2'(addr_m + 2)) begin errors++; $display("FAIL bp_addr2: got %0d expected %0d", out_addr, (addr_m + 2) % 4); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
        addr_m += 3;
    endtask

    task automatic test_wrap_start();
        logic [32:0] e [5];
        logic [31:0] im;
        @(negedge clk);
        start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (out_addr !== 2'd0 || err_cnt !== 8'd0) begin errors++; $display("FAIL start_clear: got addr %0d cnt %0d expected 0 0", out_addr, err_cnt); end
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                checks++; if (out_valid !== 1'b1 || out_instr !== e[k-1][31:0] || out_err !== e[k-1][32]) begin
                    errors++; $display("FAIL wrap_word_%0d: got %b/%h/%b expected 1/%h/%b", k - 1, out_valid, out_instr, out_err, e[k-1][31:0], e[k-1][32]);
                end
                checks++; if (out_addr !== 2'((k - 1) % 4)) begin errors++; $display("FAIL wrap_addr_%0d: got %0d expected %0d", k - 1, out_addr, (k - 1) % 4); end
            end
            if (k < 5) begin
                im = (k == 1) ? 32'd5000 : 32'(k * 3);
                set_f(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, im);
                e[k] = model_enc(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, im);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        checks++; if (err_cnt !== 8'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL wrap_end: got cnt %0d valid %b expected 1 0", err_cnt, out_valid); end
        // Erroneous word held under stall while start fires, then start with handshake.
        set_f(7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        out_ready = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_err !== 1'b1) begin errors++; $display("FAIL start_keeps_word: got %b/%b expected 1/1", out_valid, out_err); end
        checks++; if (out_addr !== 2'd0 || err_cnt !== 8'd0) begin errors++; $display("FAIL start_stall: got addr %0d cnt %0d expected 0 0", out_addr, err_cnt); end
        out_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL start_hs_valid: got %b expected 0", out_valid); end
        checks++; if (out_addr !== 2'd0 || err_cnt !== 8'd0) begin errors++; $display("FAIL start_hs_prio: got addr %0d cnt %0d expected 0 0", out_addr, err_cnt); end
        addr_m = 0; errs_m = 0;
    endtask

    task automatic test_saturate();
        set_f(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (i == 201) begin
                checks++; if (err_cnt !== 8'd200) begin errors++; $display("FAIL sat_mid: got %0d expected 200", err_cnt); end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_cap: got %0d expected 255", err_cnt); end
        checks++; if (out_addr !== 2'((addr_m + 300) % 4)) begin errors++; $display("FAIL sat_addr: got %0d expected %0d", out_addr, (addr_m + 300) % 4); end
        addr_m += 300;
        errs_m = 255;
    endtask

    task automatic rand_fields();
        case ($urandom_range(0, 9))
            0: opcode = 7'h13;  1: opcode = 7'h03;  2: opcode = 7'h67;
            3: opcode = 7'h23;  4: opcode = 7'h63;  5: opcode = 7'h6F;
            6: opcode = 7'h37;  7: opcode = 7'h17;  8: opcode = 7'h33;
            default: opcode = 7'($urandom);
        endcase
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        funct3 = 3'($urandom); funct7 = 7'($urandom);
        if ($urandom_range(0, 7) == 0) imm = $urandom;
        else case (opcode)
            7'h13, 7'h03, 7'h67, 7'h23: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
            7'h63: imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1;
            7'h6F: imm = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1;
            7'h37, 7'h17: imm = $urandom & 32'hFFFF_F000;
            default: imm = $urandom;
        endcase
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t ent;
        logic [32:0] m;
        bit in_hs, out_hs;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid_%0d: got %b expected %b", cyc, out_valid, q.size() != 0); end
            if (q.size() != 0) begin
                checks++; if (out_instr !== q[0].instr || out_err !== q[0].err) begin
                    errors++; $display("FAIL rnd_word_%0d: got %h/%b expected %h/%b", cyc, out_instr, out_err, q[0].instr, q[0].err);
                end
                checks++; if (out_addr !== 2'(addr_m)) begin errors++; $display("FAIL rnd_addr_%0d: got %0d expected %0d", cyc, out_addr, addr_m % 4); end
                if (!q[0].err && q[0].op != 7'h33) begin
                    checks++; if (dec_imm(out_instr) !== q[0].imm) begin
                        errors++; $display("FAIL rnd_roundtrip_%0d: got %h expected %h", cyc, dec_imm(out_instr), q[0].imm);
                    end
                end
            end
            checks++; if (err_cnt !== 8'(errs_m)) begin errors++; $display("FAIL rnd_err_cnt_%0d: got %0d expected %0d", cyc, err_cnt, errs_m); end
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            start     = ($urandom_range(0, 31) == 0);
            rand_fields();
            #1;
            checks++; if (in_ready !== (q.size() == 0 || out_ready)) begin errors++; $display("FAIL rnd_in_ready_%0d: got %b expected %b", cyc, in_ready, q.size() == 0 || out_ready); end
            out_hs = (q.size() != 0) && out_ready;
            in_hs  = in_valid && ((q.size() == 0) || out_ready);
            if (start) begin
                addr_m = 0; errs_m = 0;
            end else if (out_hs) begin
                addr_m++;
                if (q[0].err && errs_m < 255) errs_m++;
            end
            if (out_hs) void'(q.pop_front());
            if (in_hs) begin
                m = model_enc(opcode, rd, rs1, rs2, funct3, funct7, imm);
                ent.instr = m[31:0]; ent.err = m[32]; ent.imm = imm; ent.op = opcode;
                q.push_back(ent);
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_midstream();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        set_f(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pending: got %b expected 1", out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_async_drop: got %b expected 0", out_valid); end
        checks++; if (out_addr !== 2'd0 || err_cnt !== 8'd0) begin errors++; $display("FAIL mid_async_state: got addr %0d cnt %0d expected 0 0", out_addr, err_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_after_release: got %b expected 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_wrap_start();
        test_saturate();
        test_random();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
